// File: rtl/writeback_stage_if.sv
// rtl/writeback_stage_if.sv - MEM/WB capture bus and regfile writeback bus for writeback_stage
interface writeback_stage_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 stall;
    logic                 mem_valid;
    logic [15:0]          mem_alu_out;
    logic [15:0]          mem_rdata;
    logic [15:0]          mem_pc_plus2;
    logic [1:0]           mem_wb_sel;
    logic                 mem_addr0;
    logic [2:0]           mem_dest;
    logic                 mem_dest_r7;
    logic                 mem_load_regfile;
    logic                 mem_load_cc;

    logic [15:0]          regfilemux_out;
    logic [2:0]           destb;
    logic                 dest_r7;
    logic                 load_regfile;
    logic                 fwd_valid;
    logic [2:0]           fwd_reg;
    logic [2:0]           cc_nzp;
    logic                 retire_pulse;
    logic [CNT_WIDTH-1:0] retire_count;

    modport master (
        output stall, mem_valid, mem_alu_out, mem_rdata, mem_pc_plus2, mem_wb_sel,
               mem_addr0, mem_dest, mem_dest_r7, mem_load_regfile, mem_load_cc,
        input  regfilemux_out, destb, dest_r7, load_regfile, fwd_valid, fwd_reg,
               cc_nzp, retire_pulse, retire_count
    );

    modport slave (
        input  stall, mem_valid, mem_alu_out, mem_rdata, mem_pc_plus2, mem_wb_sel,
               mem_addr0, mem_dest, mem_dest_r7, mem_load_regfile, mem_load_cc,
        output regfilemux_out, destb, dest_r7, load_regfile, fwd_valid, fwd_reg,
               cc_nzp, retire_pulse, retire_count
    );
endinterface

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - LC-3b MEM/WB register, writeback mux, NZP register and retire counter
module writeback_stage #(
    parameter int CNT_WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    writeback_stage_if.slave   wb
);
    // Captured MEM/WB fields
    logic        wb_valid;
    logic        fresh;
    logic [15:0] wb_alu_out;
    logic [15:0] wb_rdata;
    logic [15:0] wb_pc_plus2;
    logic [1:0]  wb_sel;
    logic        wb_addr0;
    logic [2:0]  wb_dest;
    logic        wb_dest_r7;
    logic        wb_load_regfile;
    logic        wb_load_cc;

    logic [2:0]           nzp_q;
    logic [CNT_WIDTH-1:0] count_q;

    logic [15:0] wb_data;
    logic [2:0]  nzp_next;
    logic        retire;

    // Pipeline register: load on every unstalled edge; fresh marks the first cycle of an instruction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid        <= 1'b0;
            fresh           <= 1'b0;
            wb_alu_out      <= 16'h0000;
            wb_rdata        <= 16'h0000;
            wb_pc_plus2     <= 16'h0000;
            wb_sel          <= 2'b00;
            wb_addr0        <= 1'b0;
            wb_dest         <= 3'b000;
            wb_dest_r7      <= 1'b0;
            wb_load_regfile <= 1'b0;
            wb_load_cc      <= 1'b0;
        end else if (!wb.stall) begin
            wb_valid        <= wb.mem_valid;
            fresh           <= 1'b1;
            wb_alu_out      <= wb.mem_alu_out;
            wb_rdata        <= wb.mem_rdata;
            wb_pc_plus2     <= wb.mem_pc_plus2;
            wb_sel          <= wb.mem_wb_sel;
            wb_addr0        <= wb.mem_addr0;
            wb_dest         <= wb.mem_dest;
            wb_dest_r7      <= wb.mem_dest_r7;
            wb_load_regfile <= wb.mem_load_regfile;
            wb_load_cc      <= wb.mem_load_cc;
        end else begin
            fresh           <= 1'b0;
        end
    end

    // Writeback data select and the condition codes that data would produce
    always_comb begin
        wb_data = 16'h0000;
        case (wb_sel)
            2'b00:   wb_data = wb_alu_out;
            2'b01:   wb_data = wb_rdata;
            2'b10:   wb_data = {8'h00, (wb_addr0 ? wb_rdata[15:8] : wb_rdata[7:0])};
            default: wb_data = wb_pc_plus2;
        endcase
        nzp_next = 3'b001;
        if (wb_data == 16'h0000)
            nzp_next = 3'b010;
        else if (wb_data[15])
            nzp_next = 3'b100;
    end

    // Retirement happens only in an instruction's first WB cycle, so stalls never double-count
    assign retire = wb_valid & fresh;

    // NZP and retire counter update once per retired instruction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nzp_q   <= 3'b010;
            count_q <= '0;
        end else if (retire) begin
            count_q <= count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            if (wb_load_cc)
                nzp_q <= nzp_next;
        end
    end

    // Regfile port and forwarding tap; the write stays asserted across a stall (idempotent rewrite)
    always_comb begin
        wb.regfilemux_out = wb_data;
        wb.destb          = wb_dest;
        wb.dest_r7        = wb_dest_r7;
        wb.load_regfile   = wb_valid & wb_load_regfile;
        wb.fwd_valid      = wb_valid & wb_load_regfile;
        wb.fwd_reg        = wb_dest_r7 ? 3'b111 : wb_dest;
        wb.cc_nzp         = nzp_q;
        wb.retire_pulse   = retire;
        wb.retire_count   = count_q;
    end
endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - self-checking bench for writeback_stage
module tb_writeback_stage;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    writeback_stage_if #(.CNT_WIDTH(16)) bus ();
    writeback_stage #(.CNT_WIDTH(16)) dut (.clk(clk), .reset(reset), .wb(bus));

    typedef struct {
        logic        valid;
        logic [15:0] alu;
        logic [15:0] rdata;
        logic [15:0] pc2;
        logic [1:0]  sel;
        logic        a0;
        logic [2:0]  dest;
        logic        r7;
        logic        ldr;
        logic        ldcc;
    } ins_t;

    // Reference model state: the instruction in WB, whether this is its first cycle, NZP, count
    ins_t        m_cur;
    ins_t        m_in;
    logic        m_stall;
    logic        m_fresh;
    logic [2:0]  m_nzp;
    logic [15:0] m_cnt;

    function automatic ins_t bubble();
        ins_t x;
        x = '{valid: 1'b0, alu: 16'h0, rdata: 16'h0, pc2: 16'h0, sel: 2'b00, a0: 1'b0,
              dest: 3'd0, r7: 1'b0, ldr: 1'b0, ldcc: 1'b0};
        return x;
    endfunction

    function automatic ins_t mk(logic [1:0] sel, logic [15:0] alu, logic [15:0] rdata,
                                logic [15:0] pc2, logic a0, logic [2:0] dest, logic r7,
                                logic ldr, logic ldcc);
        ins_t x;
        x = '{valid: 1'b1, alu: alu, rdata: rdata, pc2: pc2, sel: sel, a0: a0,
              dest: dest, r7: r7, ldr: ldr, ldcc: ldcc};
        return x;
    endfunction

    function automatic ins_t rnd();
        ins_t x;
        x = mk(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), 16'($urandom),
               1'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        x.valid = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 4) == 0) x.alu = 16'h0000;
        return x;
    endfunction

    // Value an instruction writes, straight from the LC-3b writeback rules
    function automatic logic [15:0] result(ins_t x);
        logic [15:0] r;
        if (x.sel == 2'd0)      r = x.alu;
        else if (x.sel == 2'd1) r = x.rdata;
        else if (x.sel == 2'd2) r = x.a0 ? (x.rdata >> 8) : (x.rdata & 16'h00FF);
        else                    r = x.pc2;
        return r;
    endfunction

    function automatic logic [2:0] nzp_of(logic [15:0] d);
        if ($signed(d) < 0) return 3'b100;
        if (d == 0)         return 3'b010;
        return 3'b001;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(ins_t x, logic st);
        m_in                 = x;
        m_stall              = st;
        bus.stall            = st;
        bus.mem_valid        = x.valid;
        bus.mem_alu_out      = x.alu;
        bus.mem_rdata        = x.rdata;
        bus.mem_pc_plus2     = x.pc2;
        bus.mem_wb_sel       = x.sel;
        bus.mem_addr0        = x.a0;
        bus.mem_dest         = x.dest;
        bus.mem_dest_r7      = x.r7;
        bus.mem_load_regfile = x.ldr;
        bus.mem_load_cc      = x.ldcc;
    endtask

    task automatic model_reset();
        m_cur   = bubble();
        m_fresh = 1'b0;
        m_nzp   = 3'b010;
        m_cnt   = 16'h0000;
    endtask

    // One clock edge in both DUT and model; returns 1 ns after the edge
    task automatic step();
        @(posedge clk);
        if (m_cur.valid && m_fresh) begin
            if (m_cur.ldcc) m_nzp = nzp_of(result(m_cur));
            m_cnt = m_cnt + 16'd1;
        end
        if (!m_stall) begin
            m_cur   = m_in;
            m_fresh = 1'b1;
        end else begin
            m_fresh = 1'b0;
        end
        #1;
    endtask

    task automatic check_all(string tag);
        logic w;
        w = m_cur.valid & m_cur.ldr;
        check({tag, ".data"},  32'(bus.regfilemux_out), 32'(result(m_cur)));
        check({tag, ".destb"}, 32'(bus.destb),          32'(m_cur.dest));
        check({tag, ".r7"},    32'(bus.dest_r7),        32'(m_cur.r7));
        check({tag, ".ld"},    32'(bus.load_regfile),   32'(w));
        check({tag, ".fwdv"},  32'(bus.fwd_valid),      32'(w));
        check({tag, ".fwdr"},  32'(bus.fwd_reg),        32'(m_cur.r7 ? 3'd7 : m_cur.dest));
        check({tag, ".nzp"},   32'(bus.cc_nzp),         32'(m_nzp));
        check({tag, ".pulse"}, 32'(bus.retire_pulse),   32'(m_cur.valid & m_fresh));
        check({tag, ".cnt"},   32'(bus.retire_count),   32'(m_cnt));
    endtask

    initial begin
        int pulses;
        int guard;
        model_reset();
        drive(bubble(), 1'b0);
        #12;
        reset = 1'b0;
        check_all("init");

        // Reset asserted mid-stall while an LDR sits in WB
        drive(mk(2'd1, 16'h1234, 16'hBEEF, 16'h0, 1'b0, 3'd2, 1'b0, 1'b1, 1'b1), 1'b0);
        step();
        drive(bubble(), 1'b1);
        step();
        step();
        check("stall_ldr.ld", 32'(bus.load_regfile), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        check("async_rst.nzp", 32'(bus.cc_nzp), 32'h2);
        step();
        reset = 1'b0;
        drive(bubble(), 1'b0);

        // ADD 8000 -> R3, sets N
        drive(mk(2'd0, 16'h8000, 16'h0, 16'h0, 1'b0, 3'd3, 1'b0, 1'b1, 1'b1), 1'b0);
        step();
        check_all("add");
        check("add.destb", 32'(bus.destb), 32'd3);
        drive(bubble(), 1'b0);
        step();
        check("add.nzp", 32'(bus.cc_nzp), 32'h4);
        check("add.cnt", 32'(bus.retire_count), 32'd1);

        // LDB high/low byte and zero result
        drive(mk(2'd2, 16'h0, 16'hA55A, 16'h0, 1'b1, 3'd1, 1'b0, 1'b1, 1'b0), 1'b0);
        step();
        check("ldb_hi", 32'(bus.regfilemux_out), 32'h00A5);
        drive(mk(2'd2, 16'h0, 16'hA55A, 16'h0, 1'b0, 3'd1, 1'b0, 1'b1, 1'b0), 1'b0);
        step();
        check("ldb_lo", 32'(bus.regfilemux_out), 32'h005A);
        drive(mk(2'd2, 16'h0, 16'h00FF, 16'h0, 1'b1, 3'd1, 1'b0, 1'b1, 1'b1), 1'b0);
        step();
        check_all("ldb_zero");
        drive(bubble(), 1'b0);
        step();
        check("ldb_zero.nzp", 32'(bus.cc_nzp), 32'h2);

        // JSR link write to R7, NZP unchanged
        drive(mk(2'd3, 16'h7777, 16'h0, 16'h3004, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0), 1'b0);
        step();
        check("jsr.data", 32'(bus.regfilemux_out), 32'h3004);
        check("jsr.fwdr", 32'(bus.fwd_reg), 32'd7);
        drive(bubble(), 1'b0);
        step();
        check("jsr.nzp", 32'(bus.cc_nzp), 32'h2);

        // Instruction held by a 5-cycle stall retires once
        drive(mk(2'd0, 16'h0042, 16'h0, 16'h0, 1'b0, 3'd5, 1'b0, 1'b1, 1'b1), 1'b0);
        step();
        pulses = int'(bus.retire_pulse);
        drive(bubble(), 1'b1);
        for (int i = 0; i < 5; i++) begin
            step();
            check_all("stall5");
            check("stall5.ld", 32'(bus.load_regfile), 32'd1);
            pulses += int'(bus.retire_pulse);
        end
        check("stall5.pulses", 32'(pulses), 32'd1);
        check("stall5.nzp", 32'(bus.cc_nzp), 32'h1);
        drive(bubble(), 1'b0);
        step();
        check_all("stall5.rel");

        // Randomised traffic with random stalls
        for (int i = 0; i < 400; i++) begin
            drive(rnd(), ($urandom_range(0, 3) == 0));
            step();
            check_all("rand");
        end

        // Bubbles never write or retire
        drive(bubble(), 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            check_all("bubble");
        end

        // Retire until the counter reaches FFFF, then one more to wrap
        guard = 0;
        while (m_cnt != 16'hFFFF && guard < 70000) begin
            drive(mk(2'd0, 16'h0001, 16'h0, 16'h0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0), 1'b0);
            step();
            guard++;
        end
        check("wrap.reach", 32'(m_cnt), 32'hFFFF);
        check("wrap.ffff", 32'(bus.retire_count), 32'hFFFF);
        check("wrap.pulse", 32'(bus.retire_pulse), 32'd1);
        drive(bubble(), 1'b0);
        step();
        check("wrap.zero", 32'(bus.retire_count), 32'h0000);
        check_all("wrap");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
